// File: rtl/sensor_sample_sched.sv
// sensor_sample_sched: issues periodic or one-shot conversion requests to the
// SPI sensor master, captures each 8-bit result into a circular sample RAM and
// keeps sticky status flags for the host register block.
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   en, period            periodic timer enable and trigger period (0 = off)
//   oneshot               single-cycle request for one sample
//   clr_err               clears overrun_err, timeout_err, wrapped
//   spi_valid/spi_ready   request/done handshake with the SPI master
//   spi_data              sample from the SPI master
//   mem_we/addr/wdata     write port of the sample RAM
//   last_sample           most recent captured sample
//   sample_cnt            stored samples, saturating at 2^ADDR_W
//   busy                  FSM not idle
//   overrun_err, timeout_err, wrapped   sticky status flags
module sensor_sample_sched #(
    parameter int unsigned PERIOD_W = 24,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned TIMEOUT  = 2048
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    input  logic                oneshot,
    input  logic                clr_err,
    output logic                spi_valid,
    input  logic                spi_ready,
    input  logic [7:0]          spi_data,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [7:0]          mem_wdata,
    output logic [7:0]          last_sample,
    output logic [ADDR_W:0]     sample_cnt,
    output logic                busy,
    output logic                overrun_err,
    output logic                timeout_err,
    output logic                wrapped
);

    localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SETTLE,
        S_WRITE,
        S_RELEASE
    } state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] tmr_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic [ADDR_W-1:0]   wr_ptr;
    logic                pending;
    logic                tmr_hit_c;
    logic                trig_c;
    logic                to_hit_c;
    logic                leave_idle_c;
    logic                capture_c;

    // Period timer; >= guards against period being lowered below the count.
    assign tmr_hit_c = en && (period != '0) && (tmr_cnt >= period - PERIOD_W'(1));
    // A coincident timer hit and oneshot collapse into one trigger.
    assign trig_c    = tmr_hit_c || oneshot;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_cnt <= '0;
        end else if (!en || (period == '0) || tmr_hit_c) begin
            tmr_cnt <= '0;
        end else begin
            tmr_cnt <= tmr_cnt + PERIOD_W'(1);
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        to_hit_c     = 1'b0;
        leave_idle_c = 1'b0;
        capture_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending) begin
                    state_d      = S_REQ;
                    leave_idle_c = 1'b1;
                end
            end
            S_REQ: begin
                if (spi_ready) begin
                    state_d = S_SETTLE;
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    state_d  = S_RELEASE;
                    to_hit_c = 1'b1;
                end
            end
            S_SETTLE: begin
                // spi_data is valid now; register it for the WRITE cycle.
                state_d   = S_WRITE;
                capture_c = 1'b1;
            end
            S_WRITE: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!spi_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            to_cnt      <= '0;
            pending     <= 1'b0;
            wr_ptr      <= '0;
            spi_valid   <= 1'b0;
            busy        <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            last_sample <= '0;
            sample_cnt  <= '0;
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
            wrapped     <= 1'b0;
        end else begin
            state_q   <= state_d;
            spi_valid <= (state_d == S_REQ) || (state_d == S_SETTLE) || (state_d == S_WRITE);
            busy      <= (state_d != S_IDLE);
            mem_we    <= (state_d == S_WRITE);

            to_cnt <= (state_q == S_REQ) ? to_cnt + TO_W'(1) : '0;

            if (leave_idle_c) begin
                pending <= 1'b0;
            end else if (trig_c) begin
                pending <= 1'b1;
            end

            if (capture_c) begin
                mem_wdata   <= spi_data;
                last_sample <= spi_data;
                mem_addr    <= wr_ptr;
                wr_ptr      <= wr_ptr + ADDR_W'(1);
                if (sample_cnt != CNT_MAX) begin
                    sample_cnt <= sample_cnt + (ADDR_W + 1)'(1);
                end
            end

            // Sticky flags: a set condition beats clr_err in the same cycle.
            if (trig_c && pending) begin
                overrun_err <= 1'b1;
            end else if (clr_err) begin
                overrun_err <= 1'b0;
            end

            if (to_hit_c) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end

            if (capture_c && (&wr_ptr)) begin
                wrapped <= 1'b1;
            end else if (clr_err) begin
                wrapped <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sensor_sample_sched.sv
// Self-checking bench for sensor_sample_sched: a behavioural SPI master pushes
// each expected RAM write to a scoreboard when it returns data; a monitor pops
// and compares on every mem_we.
module tb_sensor_sample_sched;

    localparam int unsigned PERIOD_W = 24;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned TIMEOUT  = 128;
    localparam int unsigned DEPTH    = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic [PERIOD_W-1:0] period;
    logic                oneshot;
    logic                clr_err;
    logic                spi_valid;
    logic                spi_ready;
    logic [7:0]          spi_data;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [7:0]          mem_wdata;
    logic [7:0]          last_sample;
    logic [ADDR_W:0]     sample_cnt;
    logic                busy;
    logic                overrun_err;
    logic                timeout_err;
    logic                wrapped;

    sensor_sample_sched #(
        .PERIOD_W(PERIOD_W),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .period     (period),
        .oneshot    (oneshot),
        .clr_err    (clr_err),
        .spi_valid  (spi_valid),
        .spi_ready  (spi_ready),
        .spi_data   (spi_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .last_sample(last_sample),
        .sample_cnt (sample_cnt),
        .busy       (busy),
        .overrun_err(overrun_err),
        .timeout_err(timeout_err),
        .wrapped    (wrapped)
    );

    always #5 clk = ~clk;

    int                n_tests = 0;
    int                n_fail  = 0;
    int                n_writes = 0;
    int                cyc = 0;
    int                rise_q[$];
    int                last_hi = 0;
    wr_t               exp_q[$];
    logic [ADDR_W-1:0] exp_ptr = '0;
    int                exp_cnt = 0;
    logic              exp_wrapped = 1'b0;

    // SPI model controls
    int                spi_delay = 10;
    bit                spi_never = 1'b0;
    bit                spi_fixed = 1'b0;
    logic [7:0]        fixed_data = 8'h00;
    bit                suppress = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SPI master: ready after spi_delay cycles of spi_valid,
    // junk data on the ready cycle, real data one cycle later.
    initial begin
        int         cnt;
        bit         dphase;
        logic [7:0] cur;
        wr_t        e;
        cnt = 0;
        dphase = 1'b0;
        cur = 8'h00;
        spi_ready = 1'b0;
        spi_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!spi_valid) begin
                spi_ready = 1'b0;
                cnt = 0;
                dphase = 1'b0;
            end else if (dphase) begin
                spi_data = cur;
                dphase = 1'b0;
            end else if (!spi_ready && !spi_never) begin
                cnt++;
                if (cnt >= spi_delay) begin
                    cur = spi_fixed ? fixed_data : 8'($urandom);
                    spi_ready = 1'b1;
                    spi_data = ~cur;
                    dphase = 1'b1;
                    if (!suppress) begin
                        e.addr = exp_ptr;
                        e.data = cur;
                        exp_q.push_back(e);
                        exp_ptr = exp_ptr + ADDR_W'(1);
                        if (exp_cnt < DEPTH) exp_cnt++;
                        if (exp_ptr == '0) exp_wrapped = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: spi_valid edges/pulse lengths and scoreboard compare on writes
    initial begin
        bit  prev_valid;
        int  hi_run;
        wr_t e;
        prev_valid = 1'b0;
        hi_run = 0;
        forever begin
            @(negedge clk);
            if (spi_valid && !prev_valid) rise_q.push_back(cyc);
            if (spi_valid) begin
                hi_run++;
            end else if (prev_valid) begin
                last_hi = hi_run;
                hi_run = 0;
            end
            prev_valid = spi_valid;
            if (mem_we) begin
                check("we_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_writes++;
                    check("mem_addr", 32'(mem_addr), 32'(e.addr));
                    check("mem_wdata", 32'(mem_wdata), 32'(e.data));
                    check("last_sample_wr", 32'(last_sample), 32'(e.data));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_oneshot();
        @(negedge clk) oneshot = 1'b1;
        @(negedge clk) oneshot = 1'b0;
    endtask

    task automatic wait_idle();
        int quiet;
        quiet = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) quiet++;
            else quiet = 0;
            if (quiet >= 4) return;
        end
        check("idle_bound", 32'd0, 32'd1);
    endtask

    initial begin
        int  w0;
        bit  seen;
        rst = 1'b1;
        en = 1'b0;
        period = '0;
        oneshot = 1'b0;
        clr_err = 1'b0;
        tick(3);

        // Reset state
        check("rst_spi_valid", 32'(spi_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_sample_cnt", 32'(sample_cnt), 32'd0);
        check("rst_flags", 32'({overrun_err, timeout_err, wrapped}), 32'd0);
        @(negedge clk) rst = 1'b0;

        // One-shot, 0xA5, ready after 40 cycles; trigger latency N+2
        spi_fixed = 1'b1;
        fixed_data = 8'hA5;
        spi_delay = 40;
        w0 = n_writes;
        @(negedge clk) oneshot = 1'b1;
        @(negedge clk) oneshot = 1'b0;
        check("lat_n1_valid", 32'(spi_valid), 32'd0);
        @(negedge clk);
        check("lat_n2_valid", 32'(spi_valid), 32'd1);
        check("lat_n2_busy", 32'(busy), 32'd1);
        wait_idle();
        check("os_writes", 32'(n_writes - w0), 32'd1);
        check("os_last_sample", 32'(last_sample), 32'hA5);
        check("os_sample_cnt", 32'(sample_cnt), 32'd1);
        check("os_busy", 32'(busy), 32'd0);
        check("os_valid_len", 32'(last_hi), 32'd42);
        spi_fixed = 1'b0;

        // Periodic: period 200, five triggers, no overrun
        spi_delay = 66;
        period = PERIOD_W'(200);
        w0 = n_writes;
        rise_q.delete();
        @(negedge clk) en = 1'b1;
        tick(1050);
        en = 1'b0;
        wait_idle();
        check("per_writes", 32'(n_writes - w0), 32'd5);
        check("per_rises", 32'(rise_q.size()), 32'd5);
        for (int i = 1; i < rise_q.size(); i++)
            check("per_spacing", 32'(rise_q[i] - rise_q[i-1]), 32'd200);
        check("per_overrun", 32'(overrun_err), 32'd0);

        // Overrun: period 20 against a long transfer; back-to-back service
        period = PERIOD_W'(20);
        w0 = n_writes;
        rise_q.delete();
        @(negedge clk) en = 1'b1;
        tick(150);
        en = 1'b0;
        wait_idle();
        check("ovr_flag", 32'(overrun_err), 32'd1);
        check("ovr_rises", 32'(rise_q.size()), 32'd3);
        check("ovr_writes", 32'(n_writes - w0), 32'd3);
        for (int i = 1; i < rise_q.size(); i++)
            check("ovr_b2b_spacing", 32'(rise_q[i] - rise_q[i-1]), 32'(spi_delay + 4));
        check("wrap_flag", 32'(wrapped), 32'(exp_wrapped));
        check("wrap_sample_cnt", 32'(sample_cnt), 32'(exp_cnt));
        @(negedge clk) clr_err = 1'b1;
        @(negedge clk) clr_err = 1'b0;
        exp_wrapped = 1'b0;
        check("clr_overrun", 32'(overrun_err), 32'd0);
        check("clr_wrapped", 32'(wrapped), 32'd0);
        check("clr_keeps_cnt", 32'(sample_cnt), 32'(exp_cnt));

        // Timeout: no ready at all, then a normal one-shot
        spi_never = 1'b1;
        w0 = n_writes;
        pulse_oneshot();
        wait_idle();
        check("to_flag", 32'(timeout_err), 32'd1);
        check("to_valid_len", 32'(last_hi), 32'(TIMEOUT));
        check("to_no_write", 32'(n_writes - w0), 32'd0);
        check("to_sample_cnt", 32'(sample_cnt), 32'(exp_cnt));
        spi_never = 1'b0;
        spi_delay = 10;
        pulse_oneshot();
        wait_idle();
        check("to_recover_write", 32'(n_writes - w0), 32'd1);
        check("to_sticky", 32'(timeout_err), 32'd1);

        // Reset the cycle after spi_ready rises: no write, all outputs reset
        suppress = 1'b1;
        spi_delay = 20;
        pulse_oneshot();
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            if (spi_ready) seen = 1'b1;
        end
        check("rm_ready_seen", 32'(seen), 32'd1);
        w0 = n_writes;
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check("rm_spi_valid", 32'(spi_valid), 32'd0);
        check("rm_mem_we", 32'(mem_we), 32'd0);
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_outs", 32'({mem_addr, mem_wdata, last_sample}), 32'd0);
        check("rm_sample_cnt", 32'(sample_cnt), 32'd0);
        check("rm_flags", 32'({overrun_err, timeout_err, wrapped}), 32'd0);
        rst = 1'b0;
        exp_ptr = '0;
        exp_cnt = 0;
        exp_wrapped = 1'b0;
        tick(3);
        check("rm_no_write", 32'(n_writes - w0), 32'd0);
        suppress = 1'b0;
        pulse_oneshot();
        wait_idle();
        check("rm_after_write", 32'(n_writes - w0), 32'd1);
        check("rm_after_cnt", 32'(sample_cnt), 32'd1);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
